// File: rtl/ofs_plat_axi_almfull_sink_buf.sv
// ofs_plat_axi_almfull_sink_buf
//
// Receives one AXI-MM request channel (AW, W or AR) that uses the
// almost-full ready protocol. Upstream register stages forward valid
// without checking the current ready, so up to N_IN_FLIGHT beats can
// still arrive after ready drops. This block absorbs those beats in a
// FIFO. It presents a conventional first-word-fall-through ready/valid
// stream to the sink.
//
// Ports:
//   clk, reset_n   channel clock; asynchronous active-low reset
//   enq_valid      beat from the register pipeline (never gated here)
//   enq_data       beat payload
//   almfull_ready  registered almost-full ready toward the source
//   deq_valid      FIFO head valid
//   deq_data       FIFO head payload (don't-care while deq_valid=0)
//   deq_ready      downstream sink accepts the head
//   count          current occupancy, 0..DEPTH
//   overflow_err   sticky: a beat arrived with no room and was dropped
//
// Parameters:
//   N_DATA_BITS         payload width
//   N_IN_FLIGHT         beats that can arrive after ready is seen low
//   DEPTH               FIFO entries; power of 2, >= N_IN_FLIGHT+2
//   ASSERT_ON_OVERFLOW  raise a simulation error when overflow_err rises;
//                       clear it where a dropped beat is an expected event

module ofs_plat_axi_almfull_sink_buf #(
  parameter int unsigned N_DATA_BITS        = 64,
  parameter int unsigned N_IN_FLIGHT        = 2,
  parameter int unsigned DEPTH              = 8,
  parameter bit          ASSERT_ON_OVERFLOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enq_valid,
  input  logic [N_DATA_BITS-1:0]       enq_data,
  output logic                         almfull_ready,
  output logic                         deq_valid,
  output logic [N_DATA_BITS-1:0]       deq_data,
  input  logic                         deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] IN_FLIGHT_C = CW'(N_IN_FLIGHT);

  generate
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
      $error("ofs_plat_axi_almfull_sink_buf: DEPTH must be a power of 2");
    end
    if (DEPTH < N_IN_FLIGHT + 2) begin : g_bad_depth_min
      $error("ofs_plat_axi_almfull_sink_buf: DEPTH must be >= N_IN_FLIGHT+2");
    end
  endgenerate

  logic [N_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;

  logic          deq;
  logic          enq_ok;
  logic          drop;
  logic [CW-1:0] count_next;

  always_comb begin
    deq_valid  = (count != '0);
    deq_data   = mem[rd_ptr];
    deq        = deq_valid && deq_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    enq_ok     = enq_valid && ((count < DEPTH_C) || deq);
    drop       = enq_valid && !enq_ok;
    count_next = count + CW'(enq_ok) - CW'(deq);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      almfull_ready <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (deq)    rd_ptr <= rd_ptr + AW'(1);
      if (enq_ok) wr_ptr <= wr_ptr + AW'(1);
      count <= count_next;
      // Computed from count_next so ready tracks the new occupancy
      // on the same edge, with no extra lag.
      almfull_ready <= ((DEPTH_C - count_next) > IN_FLIGHT_C);
      if (drop) overflow_err <= 1'b1;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (enq_ok) mem[wr_ptr] <= enq_data;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(ASSERT_ON_OVERFLOW && drop && !overflow_err))
        else $error("ofs_plat_axi_almfull_sink_buf: beat dropped, FIFO overflow");
      assert (!(deq_valid && $isunknown(deq_ready)))
        else $error("ofs_plat_axi_almfull_sink_buf: deq_ready unknown while deq_valid");
    end
  end
`endif

endmodule

// File: tb/tb_ofs_plat_axi_almfull_sink_buf.sv
// Bench for ofs_plat_axi_almfull_sink_buf (DEPTH=8, N_IN_FLIGHT=2).
// Accepted beats go into a queue when they are driven. A negedge monitor
// pops that queue and compares each dequeued head against it. A small
// occupancy model predicts count, almfull_ready, deq_valid and overflow_err.

module tb_ofs_plat_axi_almfull_sink_buf;

  localparam int unsigned NB = 64;
  localparam int unsigned D  = 8;
  localparam int unsigned NF = 2;

  logic          clk;
  logic          reset_n;
  logic          enq_valid;
  logic [NB-1:0] enq_data;
  logic          almfull_ready;
  logic          deq_valid;
  logic [NB-1:0] deq_data;
  logic          deq_ready;
  logic [3:0]    count;
  logic          overflow_err;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] sb_q [$];
  int unsigned   m_count;
  logic          m_ovf;
  logic          m_afr;

  ofs_plat_axi_almfull_sink_buf #(
    .N_DATA_BITS       (NB),
    .N_IN_FLIGHT       (NF),
    .DEPTH             (D),
    .ASSERT_ON_OVERFLOW(1'b0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enq_valid    (enq_valid),
    .enq_data     (enq_data),
    .almfull_ready(almfull_ready),
    .deq_valid    (deq_valid),
    .deq_data     (deq_data),
    .deq_ready    (deq_ready),
    .count        (count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && deq_valid && deq_ready) begin
      if (sb_q.size() == 0) check("deq_unexpected", 64'd1, 64'd0);
      else                  check("deq_data", deq_data, sb_q.pop_front());
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_count"},   64'(count),         64'(m_count));
    check({tag, "_afr"},     64'(almfull_ready), 64'(m_afr));
    check({tag, "_dvalid"},  64'(deq_valid),     64'(m_count != 0));
    check({tag, "_ovf"},     64'(overflow_err),  64'(m_ovf));
  endtask

  // One clock: drive inputs, update the model, advance past the edge.
  task automatic cycle(input logic ev, input logic [NB-1:0] ed, input logic dr, input string tag);
    logic deq, acc;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    deq = (m_count != 0) && dr;
    acc = ev && ((m_count < D) || deq);
    if (acc) sb_q.push_back(ed);
    if (ev && !acc) m_ovf = 1'b1;
    m_count = m_count + (acc ? 1 : 0) - (deq ? 1 : 0);
    m_afr = ((D - m_count) > NF);
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_data  = '0;
    #1;
    check("rst_count",  64'(count),         64'd0);
    check("rst_dvalid", 64'(deq_valid),     64'd0);
    check("rst_afr",    64'(almfull_ready), 64'd0);
    check("rst_ovf",    64'(overflow_err),  64'd0);
    sb_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_afr   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_afr", 64'(almfull_ready), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    m_afr = 1'b1;
    check_state("rel");
  endtask

  initial begin
    reset_n   = 1'b1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_data  = '0;
    m_count   = 0;
    m_ovf     = 1'b0;
    m_afr     = 1'b0;
    #2;
    do_reset();

    // Fill to DEPTH; almfull_ready drops once count reaches 6.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 64'(i), 1'b0, "fill");
    check("fill_full_count", 64'(count), 64'd8);

    // One beat too many: dropped, sticky error.
    cycle(1'b1, 64'h9, 1'b0, "ovf");
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b0, "ovf_hold");

    // Drain: data must be 1..8 only.
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "drain");
    check("drain_sb_empty", 64'(sb_q.size()), 64'd0);

    // Full pass-through after a clean reset.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 64'h11 + 64'(i), 1'b0, "refill");
    cycle(1'b1, 64'h20, 1'b1, "pass");
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "drain2");
    check("drain2_sb_empty", 64'(sb_q.size()), 64'd0);

    // Streaming with pointer wrap.
    for (int i = 0; i < 1000; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1, "stream");
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, "stream_tail");
    check("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset mid-operation with count=5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h40 + 64'(i), 1'b0, "pre_rst");
    check("pre_rst_count", 64'(count), 64'd5);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
